// File: rtl/queue_server_dispatch.sv
// Teller-side queue consumer: latches desk presses, grants round-robin, pulses a queue decrement, announces the call.
// Optional announce chime is enabled by defining QUEUE_CHIME_EN; otherwise chime is tied low.
module queue_server_dispatch #(
  parameter int NTELLER    = 4,
  parameter int ANN_CYCLES = 8,
  parameter int TICKET_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NTELLER-1:0] next_btn,
  input  logic               empty_flag,
  output logic               serve_pulse,
  output logic [3:0]         serving_num,
  output logic [1:0]         serving_teller,
  output logic               call_active,
  output logic [NTELLER-1:0] pending,
  output logic               chime
);

  localparam int CW = (ANN_CYCLES > 1) ? $clog2(ANN_CYCLES) : 1;
  localparam logic [CW-1:0] ANN_LAST = CW'(ANN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GRANT, ANNOUNCE} state_t;

  state_t             state;
  logic [NTELLER-1:0] btn_q;
  logic [1:0]         last_grant;
  logic [CW-1:0]      ann_cnt;

  logic [NTELLER-1:0] rise;
  logic [NTELLER-1:0] clr;
  logic [1:0]         pick;
  logic               found;
  logic [2:0]         idx;
  logic [3:0]         next_num;

  assign rise     = next_btn & ~btn_q;
  assign next_num = (serving_num >= 4'(TICKET_MAX)) ? 4'd1 : serving_num + 4'd1;

  // Search starts one past the last granted desk so every desk gets a fair turn.
  always_comb begin
    pick  = last_grant;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NTELLER; k++) begin
      idx = {1'b0, last_grant} + 3'(k);
      if (idx >= 3'(NTELLER)) idx = idx - 3'(NTELLER);
      if (!found && pending[idx[1:0]]) begin
        pick  = idx[1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    clr = '0;
    if (state == GRANT && found) clr[pick] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      btn_q          <= '0;
      last_grant     <= 2'(NTELLER - 1);
      ann_cnt        <= '0;
      pending        <= '0;
      serve_pulse    <= 1'b0;
      serving_num    <= 4'd0;
      serving_teller <= 2'd0;
      call_active    <= 1'b0;
    end else begin
      btn_q       <= next_btn;
      serve_pulse <= 1'b0;
      // A new rise on the desk being granted wins over the clear.
      pending     <= (pending & ~clr) | rise;
      case (state)
        IDLE: begin
          if (|pending && !empty_flag) state <= GRANT;
        end
        GRANT: begin
          if (found) begin
            serving_teller <= pick;
            last_grant     <= pick;
            serving_num    <= next_num;
            serve_pulse    <= 1'b1;
            call_active    <= 1'b1;
            ann_cnt        <= '0;
            state          <= ANNOUNCE;
          end else begin
            state <= IDLE;
          end
        end
        ANNOUNCE: begin
          if (ann_cnt == ANN_LAST) begin
            call_active <= 1'b0;
            state       <= IDLE;
          end else begin
            ann_cnt <= ann_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef QUEUE_CHIME_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chime <= 1'b0;
    end else if (state == GRANT && found) begin
      chime <= 1'b1;
    end else if (state == ANNOUNCE && ann_cnt != ANN_LAST) begin
      chime <= ~chime;
    end else begin
      chime <= 1'b0;
    end
  end
`else
  assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_queue_server_dispatch.sv
// Scoreboard bench for queue_server_dispatch: directed presses push expected grants, a monitor checks each serve_pulse.
module tb_queue_server_dispatch;
  localparam int ANN = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] next_btn = 4'b0;
  logic       empty_flag = 1'b1;
  logic       serve_pulse;
  logic [3:0] serving_num;
  logic [1:0] serving_teller;
  logic       call_active;
  logic [3:0] pending;
  logic       chime;

  queue_server_dispatch #(.NTELLER(4), .ANN_CYCLES(ANN), .TICKET_MAX(15)) dut (
    .clk(clk), .reset(reset), .next_btn(next_btn), .empty_flag(empty_flag),
    .serve_pulse(serve_pulse), .serving_num(serving_num), .serving_teller(serving_teller),
    .call_active(call_active), .pending(pending), .chime(chime)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int num;
    int teller;
    int at;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(int num, int tel, int at);
    exp_t e;
    e.num = num;
    e.teller = tel;
    e.at = at;
    sbq.push_back(e);
  endtask

  function automatic int exp_chime(int k);
`ifdef QUEUE_CHIME_EN
    return ((k % 2) == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // Monitor: every serve_pulse must match the oldest expected grant.
  exp_t mon_e;
  int last_serve = -100;
  always @(negedge clk) begin
    if (!reset && serve_pulse) begin
      if (sbq.size() == 0) begin
        chk("unexpected_serve", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("serve_num", serving_num, mon_e.num);
        chk("serve_teller", serving_teller, mon_e.teller);
        chk("serve_cycle", cyc, mon_e.at);
      end
      total++;
      if (cyc - last_serve < ANN + 2) begin
        bad++;
        $display("FAIL serve_spacing: got %0d expected at least %0d", cyc - last_serve, ANN + 2);
      end
      last_serve = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e_cyc;
    int k;
    int n;
    int num;
    int d;

    // Reset state
    step(3);
    chk("rst_serve_pulse", serve_pulse, 0);
    chk("rst_serving_num", serving_num, 0);
    chk("rst_serving_teller", serving_teller, 0);
    chk("rst_call_active", call_active, 0);
    chk("rst_pending", pending, 0);
    chk("rst_chime", chime, 0);
    reset = 1'b0;
    step(2);
    empty_flag = 1'b0;
    step();

    // Single call on desk 2
    e_cyc = cyc + 1;
    next_btn = 4'b0100;
    push(1, 2, e_cyc + 2);
    step();
    chk("pend_single", pending, 4'b0100);
    next_btn = 4'b0;
    k = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (call_active) begin
        chk("chime_pattern", chime, exp_chime(k));
        k++;
      end
    end
    chk("ann_len", k, ANN);
    chk("chime_off", chime, 0);

    // Empty hold on desk 0
    empty_flag = 1'b1;
    step();
    next_btn = 4'b0001;
    step();
    chk("pend_hold", pending, 4'b0001);
    next_btn = 4'b0;
    step(15);
    chk("pend_held", pending, 4'b0001);
    chk("no_call_empty", call_active, 0);
    push(2, 0, cyc + 2);
    empty_flag = 1'b0;
    step(14);
    chk("pend_clear", pending, 0);

    // Reset in the middle of an announce, with a request pending
    e_cyc = cyc + 1;
    next_btn = 4'b1000;
    push(3, 3, e_cyc + 2);
    step();
    next_btn = 4'b0;
    n = 0;
    while (!call_active && n < 10) begin
      step();
      n++;
    end
    chk("ann_reached", call_active, 1);
    next_btn = 4'b0001;
    step();
    next_btn = 4'b0;
    step(2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_serve_pulse", serve_pulse, 0);
    chk("mid_rst_serving_num", serving_num, 0);
    chk("mid_rst_serving_teller", serving_teller, 0);
    chk("mid_rst_call_active", call_active, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_chime", chime, 0);
    step(2);
    reset = 1'b0;
    step(2);

    // Round-robin: all desks at once, starting from desk 0
    e_cyc = cyc + 1;
    next_btn = 4'b1111;
    push(1, 0, e_cyc + 2);
    push(2, 1, e_cyc + 12);
    push(3, 2, e_cyc + 22);
    push(4, 3, e_cyc + 32);
    step();
    chk("pend_rr", pending, 4'b1111);
    next_btn = 4'b0;
    step(45);
    chk("rr_pend_done", pending, 0);

    // Ticket wrap: grants 5..15 then the 16th wraps to 1
    num = 4;
    for (int i = 0; i < 12; i++) begin
      d = i % 4;
      num = (num == 15) ? 1 : num + 1;
      e_cyc = cyc + 1;
      next_btn = 4'(1 << d);
      push(num, d, e_cyc + 2);
      step();
      next_btn = 4'b0;
      step(11);
    end
    chk("wrap_num", serving_num, 1);

    // Held button yields a single request
    e_cyc = cyc + 1;
    next_btn = 4'b0100;
    push(2, 2, e_cyc + 2);
    step(50);
    next_btn = 4'b0;
    step(12);
    chk("hold_pend", pending, 0);
    chk("hold_num", serving_num, 2);

    // Collision: desk 1 re-presses on the edge it is granted
    e_cyc = cyc + 1;
    next_btn = 4'b0010;
    push(3, 1, e_cyc + 2);
    push(4, 1, e_cyc + 12);
    step();
    next_btn = 4'b0;
    step();
    next_btn = 4'b0010;
    step();
    chk("coll_pend", pending, 4'b0010);
    chk("coll_pulse", serve_pulse, 1);
    next_btn = 4'b0;
    step(25);
    chk("coll_num", serving_num, 4);
    chk("coll_teller", serving_teller, 1);
    chk("coll_pend_done", pending, 0);

    chk("sb_drain", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
